scr1_tb_ahb_arb2: RTL and testbench

Two-master to one-slave AHB-Lite arbiter for the SCR1 AHB testbench. It merges the core's imem (read-only) and dmem AHB master ports onto a single unified slave port, so the core can run against one shared memory model. It sits between scr1_top_ahb and the testbench memory. It buffers address phases that lose arbitration and routes each data phase back to the master that owns it.

---
 rtl/scr1_tb_ahb_arb2.sv | 176 +++++++++++++++++
 tb/tb_scr1_tb_ahb_arb2.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_ahb_arb2.sv
// Two-master (imem, dmem) to one-slave AHB-Lite arbiter for the SCR1 AHB testbench.
// Optional macro SCR1_TB_AHB_ARB_RR_EN selects round-robin arbitration instead of fixed DMEM > IMEM.
module scr1_tb_ahb_arb2 #(
    parameter int unsigned AHB_AW = 32,
    parameter int unsigned AHB_DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        imem_htrans,
    input  logic [AHB_AW-1:0] imem_haddr,
    input  logic [2:0]        imem_hsize,
    output logic              imem_hready,
    output logic [AHB_DW-1:0] imem_hrdata,
    output logic              imem_hresp,
    input  logic [1:0]        dmem_htrans,
    input  logic [AHB_AW-1:0] dmem_haddr,
    input  logic [2:0]        dmem_hsize,
    input  logic              dmem_hwrite,
    input  logic [AHB_DW-1:0] dmem_hwdata,
    output logic              dmem_hready,
    output logic [AHB_DW-1:0] dmem_hrdata,
    output logic              dmem_hresp,
    output logic [1:0]        s_htrans,
    output logic [AHB_AW-1:0] s_haddr,
    output logic [2:0]        s_hsize,
    output logic              s_hwrite,
    output logic [AHB_DW-1:0] s_hwdata,
    input  logic              s_hready,
    input  logic [AHB_DW-1:0] s_hrdata,
    input  logic              s_hresp
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IMEM = 2'b01,
        OWN_DMEM = 2'b10
    } owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    owner_e              owner_q, owner_d;
    logic                ipend_vld_q, ipend_vld_d;
    logic [AHB_AW-1:0]   ipend_addr_q, ipend_addr_d;
    logic [2:0]          ipend_size_q, ipend_size_d;
    logic                dpend_vld_q, dpend_vld_d;
    logic [AHB_AW-1:0]   dpend_addr_q, dpend_addr_d;
    logic [2:0]          dpend_size_q, dpend_size_d;
    logic                dpend_write_q, dpend_write_d;
    logic [AHB_AW-1:0]   s_addr_q, s_addr_d;
    logic [2:0]          s_size_q, s_size_d;
    logic                s_write_q, s_write_d;
`ifdef SCR1_TB_AHB_ARB_RR_EN
    owner_e              last_gnt_q, last_gnt_d;
`endif

    logic i_live, d_live, i_req, d_req, i_gnt, d_gnt, arb_en;
    logic unused_htrans0;

    // Only htrans[1] matters: SEQ behaves as NONSEQ, BUSY as IDLE.
    assign unused_htrans0 = imem_htrans[0] ^ dmem_htrans[0];

    always_comb begin
        imem_hready = (owner_q == OWN_IMEM) ? s_hready : ~ipend_vld_q;
        dmem_hready = (owner_q == OWN_DMEM) ? s_hready : ~dpend_vld_q;
        i_live      = imem_htrans[1] & imem_hready;
        d_live      = dmem_htrans[1] & dmem_hready;
        i_req       = ipend_vld_q | i_live;
        d_req       = dpend_vld_q | d_live;
        arb_en      = s_hready & rst_n;
`ifdef SCR1_TB_AHB_ARB_RR_EN
        d_gnt = arb_en & d_req & (~i_req | (last_gnt_q == OWN_IMEM));
        i_gnt = arb_en & i_req & (~d_req | (last_gnt_q == OWN_DMEM));
`else
        d_gnt = arb_en & d_req;
        i_gnt = arb_en & i_req & ~d_req;
`endif
    end

    always_comb begin
        owner_d       = owner_q;
        ipend_vld_d   = ipend_vld_q;
        ipend_addr_d  = ipend_addr_q;
        ipend_size_d  = ipend_size_q;
        dpend_vld_d   = dpend_vld_q;
        dpend_addr_d  = dpend_addr_q;
        dpend_size_d  = dpend_size_q;
        dpend_write_d = dpend_write_q;
        s_addr_d      = s_addr_q;
        s_size_d      = s_size_q;
        s_write_d     = s_write_q;
        s_htrans      = HTRANS_IDLE;
`ifdef SCR1_TB_AHB_ARB_RR_EN
        last_gnt_d    = last_gnt_q;
`endif

        if (d_gnt) begin
            s_htrans    = HTRANS_NONSEQ;
            s_addr_d    = dpend_vld_q ? dpend_addr_q  : dmem_haddr;
            s_size_d    = dpend_vld_q ? dpend_size_q  : dmem_hsize;
            s_write_d   = dpend_vld_q ? dpend_write_q : dmem_hwrite;
            dpend_vld_d = 1'b0;
        end else if (i_gnt) begin
            s_htrans    = HTRANS_NONSEQ;
            s_addr_d    = ipend_vld_q ? ipend_addr_q : imem_haddr;
            s_size_d    = ipend_vld_q ? ipend_size_q : imem_hsize;
            s_write_d   = 1'b0;
            ipend_vld_d = 1'b0;
        end

        if (arb_en) begin
            owner_d = d_gnt ? OWN_DMEM : (i_gnt ? OWN_IMEM : OWN_NONE);
`ifdef SCR1_TB_AHB_ARB_RR_EN
            if (d_gnt) last_gnt_d = OWN_DMEM;
            else if (i_gnt) last_gnt_d = OWN_IMEM;
`endif
        end

        // A live address phase that was not taken is held here; the master already sees it accepted.
        if (i_live & ~i_gnt) begin
            ipend_vld_d  = 1'b1;
            ipend_addr_d = imem_haddr;
            ipend_size_d = imem_hsize;
        end
        if (d_live & ~d_gnt) begin
            dpend_vld_d   = 1'b1;
            dpend_addr_d  = dmem_haddr;
            dpend_size_d  = dmem_hsize;
            dpend_write_d = dmem_hwrite;
        end

        s_haddr     = s_addr_d;
        s_hsize     = s_size_d;
        s_hwrite    = s_write_d;
        s_hwdata    = (owner_q == OWN_DMEM) ? dmem_hwdata : '0;
        imem_hrdata = (owner_q == OWN_IMEM) ? s_hrdata : '0;
        imem_hresp  = (owner_q == OWN_IMEM) ? s_hresp : 1'b0;
        dmem_hrdata = (owner_q == OWN_DMEM) ? s_hrdata : '0;
        dmem_hresp  = (owner_q == OWN_DMEM) ? s_hresp : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q       <= OWN_NONE;
            ipend_vld_q   <= 1'b0;
            ipend_addr_q  <= '0;
            ipend_size_q  <= '0;
            dpend_vld_q   <= 1'b0;
            dpend_addr_q  <= '0;
            dpend_size_q  <= '0;
            dpend_write_q <= 1'b0;
            s_addr_q      <= '0;
            s_size_q      <= '0;
            s_write_q     <= 1'b0;
`ifdef SCR1_TB_AHB_ARB_RR_EN
            last_gnt_q    <= OWN_IMEM;
`endif
        end else begin
            owner_q       <= owner_d;
            ipend_vld_q   <= ipend_vld_d;
            ipend_addr_q  <= ipend_addr_d;
            ipend_size_q  <= ipend_size_d;
            dpend_vld_q   <= dpend_vld_d;
            dpend_addr_q  <= dpend_addr_d;
            dpend_size_q  <= dpend_size_d;
            dpend_write_q <= dpend_write_d;
            s_addr_q      <= s_addr_d;
            s_size_q      <= s_size_d;
            s_write_q     <= s_write_d;
`ifdef SCR1_TB_AHB_ARB_RR_EN
            last_gnt_q    <= last_gnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_scr1_tb_ahb_arb2.sv
// Self-checking bench for scr1_tb_ahb_arb2: directed scenarios then random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_scr1_tb_ahb_arb2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    imem_htrans = 2'b00;
    logic [AW-1:0] imem_haddr = '0;
    logic [2:0]    imem_hsize = 3'd2;
    logic          imem_hready;
    logic [DW-1:0] imem_hrdata;
    logic          imem_hresp;
    logic [1:0]    dmem_htrans = 2'b10;
    logic [AW-1:0] dmem_haddr = 32'h40;
    logic [2:0]    dmem_hsize = 3'd2;
    logic          dmem_hwrite = 1'b0;
    logic [DW-1:0] dmem_hwdata = '0;
    logic          dmem_hready;
    logic [DW-1:0] dmem_hrdata;
    logic          dmem_hresp;
    logic [1:0]    s_htrans;
    logic [AW-1:0] s_haddr;
    logic [2:0]    s_hsize;
    logic          s_hwrite;
    logic [DW-1:0] s_hwdata;
    logic          s_hready = 1'b1;
    logic [DW-1:0] s_hrdata = 32'hA5A5_0001;
    logic          s_hresp = 1'b0;

    always #5 clk = ~clk;

    scr1_tb_ahb_arb2 #(.AHB_AW(AW), .AHB_DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
        .imem_hready(imem_hready), .imem_hrdata(imem_hrdata), .imem_hresp(imem_hresp),
        .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
        .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
        .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hsize(s_hsize), .s_hwrite(s_hwrite),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = imem, 1 = dmem; owner -1 = nobody.
    bit          m_pvld[2];
    logic [31:0] m_paddr[2];
    logic [2:0]  m_psize[2];
    logic        m_pwr[2];
    int          m_owner;
    int          m_last;
    logic [31:0] m_haddr;
    logic [2:0]  m_hsize;
    logic        m_hwrite;

    bit          e_hr[2];
    bit          e_live[2];
    bit          e_req[2];
    int          e_win;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic        e_write;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] in_trans(int m);
        return (m == 1) ? dmem_htrans : imem_htrans;
    endfunction
    function automatic logic [31:0] in_addr(int m);
        return (m == 1) ? dmem_haddr : imem_haddr;
    endfunction
    function automatic logic [2:0] in_size(int m);
        return (m == 1) ? dmem_hsize : imem_hsize;
    endfunction
    function automatic logic in_write(int m);
        return (m == 1) ? dmem_hwrite : 1'b0;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pvld[m] = 0; m_paddr[m] = '0; m_psize[m] = '0; m_pwr[m] = 1'b0;
        end
        m_owner = -1; m_last = 0;
        m_haddr = '0; m_hsize = '0; m_hwrite = 1'b0;
        e_hr[0] = 1; e_hr[1] = 1;
    endfunction

    function automatic void model_eval();
        logic [1:0] tr;
        for (int m = 0; m < 2; m++) begin
            tr = in_trans(m);
            e_hr[m]   = (m_owner == m) ? (s_hready === 1'b1) : !m_pvld[m];
            e_live[m] = tr[1] && e_hr[m];
            e_req[m]  = m_pvld[m] || e_live[m];
        end
        e_win = -1;
        if (s_hready) begin
`ifdef SCR1_TB_AHB_ARB_RR_EN
            if (e_req[0] && e_req[1]) e_win = 1 - m_last;
`else
            if (e_req[0] && e_req[1]) e_win = 1;
`endif
            else if (e_req[1]) e_win = 1;
            else if (e_req[0]) e_win = 0;
        end
        if (e_win >= 0) begin
            e_trans = 2'b10;
            e_addr  = m_pvld[e_win] ? m_paddr[e_win] : in_addr(e_win);
            e_size  = m_pvld[e_win] ? m_psize[e_win] : in_size(e_win);
            e_write = m_pvld[e_win] ? m_pwr[e_win]   : in_write(e_win);
        end else begin
            e_trans = 2'b00; e_addr = m_haddr; e_size = m_hsize; e_write = m_hwrite;
        end
    endfunction

    function automatic void model_update();
        if (s_hready) begin
            m_owner = e_win;
            if (e_win >= 0) begin
                m_haddr = e_addr; m_hsize = e_size; m_hwrite = e_write;
                m_pvld[e_win] = 0;
                m_last = e_win;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (e_live[m] && m != e_win) begin
                m_pvld[m] = 1; m_paddr[m] = in_addr(m); m_psize[m] = in_size(m); m_pwr[m] = in_write(m);
            end
        end
    endfunction

    task automatic settle();
        #3;
        model_eval();
        chk("s_htrans", 32'(s_htrans), 32'(e_trans));
        chk("s_haddr", s_haddr, e_addr);
        chk("s_hsize", 32'(s_hsize), 32'(e_size));
        chk("s_hwrite", 32'(s_hwrite), 32'(e_write));
        chk("s_hwdata", s_hwdata, (m_owner == 1) ? dmem_hwdata : 32'h0);
        chk("imem_hready", 32'(imem_hready), 32'(e_hr[0]));
        chk("dmem_hready", 32'(dmem_hready), 32'(e_hr[1]));
        chk("imem_hrdata", imem_hrdata, (m_owner == 0) ? s_hrdata : 32'h0);
        chk("dmem_hrdata", dmem_hrdata, (m_owner == 1) ? s_hrdata : 32'h0);
        chk("imem_hresp", 32'(imem_hresp), (m_owner == 0) ? 32'(s_hresp) : 32'h0);
        chk("dmem_hresp", 32'(dmem_hresp), (m_owner == 1) ? 32'(s_hresp) : 32'h0);
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_htrans"}, 32'(s_htrans), 32'h0);
        chk({tag, "_s_haddr"}, s_haddr, 32'h0);
        chk({tag, "_s_hsize"}, 32'(s_hsize), 32'h0);
        chk({tag, "_s_hwrite"}, 32'(s_hwrite), 32'h0);
        chk({tag, "_s_hwdata"}, s_hwdata, 32'h0);
        chk({tag, "_imem_hready"}, 32'(imem_hready), 32'h1);
        chk({tag, "_dmem_hready"}, 32'(dmem_hready), 32'h1);
        chk({tag, "_imem_hrdata"}, imem_hrdata, 32'h0);
        chk({tag, "_dmem_hrdata"}, dmem_hrdata, 32'h0);
        chk({tag, "_imem_hresp"}, 32'(imem_hresp), 32'h0);
        chk({tag, "_dmem_hresp"}, 32'(dmem_hresp), 32'h0);
    endtask

    // Reset is held across one clock edge with dmem requesting and the slave ready.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        check_reset_outputs(tag);
        rst_n = 1'b1;
    endtask

    task automatic drv(input logic [1:0] itr, input logic [31:0] ia,
                       input logic [1:0] dtr, input logic [31:0] da, input logic dw,
                       input logic [31:0] dwd, input logic shr, input logic [31:0] srd,
                       input logic srsp);
        imem_htrans = itr; imem_haddr = ia;
        dmem_htrans = dtr; dmem_haddr = da; dmem_hwrite = dw; dmem_hwdata = dwd;
        s_hready = shr; s_hrdata = srd; s_hresp = srsp;
    endtask

    initial begin
        logic [3:0] pat;

        // Reset with dmem NONSEQ asserted; first grant waits for s_hready=1.
        #2;
        do_reset("rst0");
        drv(2'b00, 32'h0, 2'b10, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("post_rst_idle", 32'(s_htrans), 32'h0);
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        settle();
        chk("first_grant_trans", 32'(s_htrans), 32'h2);
        chk("first_grant_addr", s_haddr, 32'h40);
        advance();

        // Uncontested imem read, zero added latency.
        drv(2'b10, 32'h200, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        settle();
        chk("imem_addr_same_cycle", s_haddr, 32'h200);
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        settle();
        chk("imem_rdata", imem_hrdata, 32'h1234_5678);
        chk("imem_rdata_ready", 32'(imem_hready), 32'h1);
        chk("dmem_rdata_zero", dmem_hrdata, 32'h0);
        advance();

        // Simultaneous imem read and dmem write: dmem first, imem from pend regs.
        drv(2'b10, 32'h100, 2'b10, 32'h8000, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
        settle();
        chk("conflict_dmem_addr", s_haddr, 32'h8000);
        chk("conflict_dmem_write", 32'(s_hwrite), 32'h1);
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
        settle();
        chk("conflict_hwdata", s_hwdata, 32'hDEAD_BEEF);
        chk("conflict_imem_stall", 32'(imem_hready), 32'h0);
        chk("conflict_imem_pend_addr", s_haddr, 32'h100);
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0100, 1'b0);
        settle();
        chk("conflict_imem_rdata", imem_hrdata, 32'hCAFE_0100);
        advance();

        // dmem read with 3 wait states; imem arrives in wait state 1.
        drv(2'b00, 32'h0, 2'b10, 32'h8004, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        settle();
        advance();
        drv(2'b10, 32'h300, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("ws1_idle", 32'(s_htrans), 32'h0);
        chk("ws1_addr_hold", s_haddr, 32'h8004);
        advance();
        for (int w = 0; w < 2; w++) begin
            drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            settle();
            chk("ws_addr_hold", s_haddr, 32'h8004);
            chk("ws_imem_stall", 32'(imem_hready), 32'h0);
            advance();
        end
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_8004, 1'b0);
        settle();
        chk("ws_done_dmem_rdata", dmem_hrdata, 32'h5555_8004);
        chk("ws_done_imem_grant", s_haddr, 32'h300);
        chk("ws_done_imem_trans", 32'(s_htrans), 32'h2);
        advance();

        // Two-cycle ERROR response on a dmem access.
        drv(2'b00, 32'h0, 2'b10, 32'h8008, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        settle();
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        settle();
        chk("err1_dmem_hresp", 32'(dmem_hresp), 32'h1);
        chk("err1_imem_hresp", 32'(imem_hresp), 32'h0);
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        settle();
        chk("err2_dmem_hresp", 32'(dmem_hresp), 32'h1);
        chk("err2_dmem_hready", 32'(dmem_hready), 32'h1);
        advance();

        // Continuous requests from both masters: grant order from fresh reset.
        do_reset("rst1");
`ifdef SCR1_TB_AHB_ARB_RR_EN
        pat = 4'b1010;
`else
        pat = 4'b1111;
`endif
        for (int k = 0; k < 4; k++) begin
            drv(2'b10, 32'h100, 2'b10, 32'h8000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
            settle();
            chk("grant_order", 32'(s_haddr[15]), 32'(pat[3-k]));
            advance();
        end

        // Random traffic; masters only move on after their hready was seen high.
        for (int n = 0; n < 3000; n++) begin
            if (e_hr[0]) begin
                imem_htrans = 2'($urandom_range(0, 3));
                imem_haddr  = $urandom & 32'hFFFF_FFFC;
                imem_hsize  = 3'($urandom_range(0, 2));
            end
            if (e_hr[1]) begin
                dmem_htrans = 2'($urandom_range(0, 3));
                dmem_haddr  = $urandom;
                dmem_hsize  = 3'($urandom_range(0, 2));
                dmem_hwrite = 1'($urandom_range(0, 1));
                dmem_hwdata = $urandom;
            end
            s_hready = ($urandom_range(0, 3) != 0);
            s_hrdata = $urandom;
            s_hresp  = ($urandom_range(0, 7) == 0);
            settle();
            advance();
        end

        // Reset in the middle of traffic, then restart cleanly.
        drv(2'b10, 32'h444, 2'b10, 32'h8888, 1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 1'b1);
        do_reset("rst_mid");
        drv(2'b10, 32'h444, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        settle();
        chk("post_mid_rst_grant", s_haddr, 32'h444);
        advance();
        drv(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);
        settle();
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
